ecc_result_streamer: RTL and testbench

- Downstream stage of the GF(2^233) point-multiplication controller.
- Captures the affine result (x_final, y_final) when the controller's mul_done rises.
- Streams the result as sixteen 32-bit words over a valid/ready interface to the host/bus side.
- Lets the controller sit in its terminal state while the consumer drains the result at its own pace.

---
 rtl/ecc_pkg.sv | 21 ++
 rtl/ecc_word_mux.sv | 30 +++
 rtl/ecc_result_streamer.sv | 114 +++++++++++
 tb/tb_ecc_result_streamer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg -- shared GF(2^233) widths, curve constants and streamer state encoding.
// Rev 1.0
`default_nettype none
package ecc_pkg;
   localparam int FIELD_W = 233;
   localparam int WORD_W  = 32;
   localparam int NWORDS  = 8;

   // Written 256 bits wide so the hex reads word-aligned; trimmed to the field width below.
   localparam logic [255:0] PX_EXT = 256'h000000FA_C9DFCBAC_8313BB21_39F1BB75_5FEF65BC_391F8B36_F8F8EB73_71FD558B;
   localparam logic [255:0] PY_EXT = 256'h00000100_6A08A419_03350678_E58528BE_BF8A0BEF_F867A7CA_36716F7E_01F81052;
   localparam logic [255:0] B_EXT  = 256'h00000066_647EDE6C_332C7F8C_0923BB58_213B333B_20E9CE42_81FE115F_7D8F90AD;

   localparam logic [FIELD_W-1:0] PX = PX_EXT[FIELD_W-1:0];
   localparam logic [FIELD_W-1:0] PY = PY_EXT[FIELD_W-1:0];
   localparam logic [FIELD_W-1:0] B  = B_EXT[FIELD_W-1:0];

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;
endpackage
`default_nettype wire

// File: rtl/ecc_word_mux.sv
// ecc_word_mux -- picks one word of {x, y}; index 0 is the most significant x word.
// Rev 1.0
`default_nettype none
module ecc_word_mux #(
   parameter int WORD_W = 32,
   parameter int NWORDS = 8
) (
   input  logic [NWORDS*WORD_W-1:0]     i_x,
   input  logic [NWORDS*WORD_W-1:0]     i_y,
   input  logic [$clog2(2*NWORDS)-1:0]  i_idx,
   output logic [WORD_W-1:0]            o_word
);
   import ecc_pkg::*;

   localparam int SH_W  = NWORDS * WORD_W;
   localparam int IDX_W = $clog2(2 * NWORDS);

   logic [2*SH_W-1:0] w_cat;
   assign w_cat = {i_x, i_y};

   always_comb begin
      o_word = '0;
      for (int k = 0; k < 2 * NWORDS; k++) begin
         if (i_idx == IDX_W'(k)) begin
            o_word = w_cat[2*SH_W-1-k*WORD_W -: WORD_W];
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/ecc_result_streamer.sv
// ecc_result_streamer -- captures (x_final, y_final) on mul_done rise and streams 16 words.
// Rev 1.0
`default_nettype none
module ecc_result_streamer #(
   parameter int FIELD_W = ecc_pkg::FIELD_W,
   parameter int WORD_W  = ecc_pkg::WORD_W,
   parameter int NWORDS  = ecc_pkg::NWORDS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [FIELD_W-1:0]           x_final,
   input  logic [FIELD_W-1:0]           y_final,
   input  logic                         mul_done,
   output logic [WORD_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic [$clog2(2*NWORDS)-1:0]  out_idx,
   output logic                         busy,
   output logic                         overrun
);
   import ecc_pkg::*;

   localparam int SH_W  = NWORDS * WORD_W;
   localparam int IDX_W = $clog2(2 * NWORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NWORDS - 1);

   generate
      if (NWORDS != (FIELD_W + WORD_W - 1) / WORD_W) begin : g_bad_nwords
         $error("NWORDS must equal ceil(FIELD_W/WORD_W)");
      end
   endgenerate

   logic [0:0]        r_state;
   logic              r_md_q;
   logic [SH_W-1:0]   r_x;
   logic [SH_W-1:0]   r_y;
   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] r_data;
   logic              r_ovr;

   logic              w_rise;
   logic              w_hs;
   logic              w_final;
   logic              w_cap;
   logic              w_ovr_set;
   logic [SH_W-1:0]   w_x_ext;
   logic [SH_W-1:0]   w_y_ext;
   logic [SH_W-1:0]   w_src_x;
   logic [SH_W-1:0]   w_src_y;
   logic [IDX_W-1:0]  w_mux_idx;
   logic [WORD_W-1:0] w_word;

   assign w_rise    = mul_done & ~r_md_q;
   assign w_hs      = (r_state == ST_SEND) & out_ready;
   assign w_final   = w_hs & (r_idx == LAST_IDX);
   // A rise on the closing handshake starts the next result with no idle gap.
   assign w_cap     = w_rise & ((r_state == ST_IDLE) | w_final);
   assign w_ovr_set = w_rise & (r_state == ST_SEND) & ~w_final;

   assign w_x_ext   = {{(SH_W-FIELD_W){1'b0}}, x_final};
   assign w_y_ext   = {{(SH_W-FIELD_W){1'b0}}, y_final};
   assign w_src_x   = w_cap ? w_x_ext : r_x;
   assign w_src_y   = w_cap ? w_y_ext : r_y;
   assign w_mux_idx = w_cap ? '0 : r_idx + 1'b1;

   ecc_word_mux #(
      .WORD_W (WORD_W),
      .NWORDS (NWORDS)
   ) u_word_mux (
      .i_x    (w_src_x),
      .i_y    (w_src_y),
      .i_idx  (w_mux_idx),
      .o_word (w_word)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_md_q  <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_idx   <= '0;
         r_data  <= '0;
         r_ovr   <= 1'b0;
      end else begin
         r_md_q <= mul_done;
         if (w_ovr_set) begin
            r_ovr <= 1'b1;
         end
         if (w_cap) begin
            r_x     <= w_x_ext;
            r_y     <= w_y_ext;
            r_idx   <= '0;
            r_data  <= w_word;
            r_state <= ST_SEND;
         end else if (w_final) begin
            r_idx   <= '0;
            r_state <= ST_IDLE;
         end else if (w_hs) begin
            r_idx  <= w_mux_idx;
            r_data <= w_word;
         end
      end
   end

   assign out_data  = r_data;
   assign out_valid = (r_state == ST_SEND);
   assign busy      = (r_state == ST_SEND);
   assign out_last  = (r_state == ST_SEND) && (r_idx == LAST_IDX);
   assign out_idx   = r_idx;
   assign overrun   = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_ecc_result_streamer.sv
// tb_ecc_result_streamer -- directed vector table plus hand sequences for the streamer.
// Rev 1.0
`default_nettype none
module tb_ecc_result_streamer;
   import ecc_pkg::*;

   logic                clk;
   logic                reset;
   logic [FIELD_W-1:0]  x_final;
   logic [FIELD_W-1:0]  y_final;
   logic                mul_done;
   logic [31:0]         out_data;
   logic                out_valid;
   logic                out_ready;
   logic                out_last;
   logic [3:0]          out_idx;
   logic                busy;
   logic                overrun;

   ecc_result_streamer u_dut (
      .clk       (clk),
      .reset     (reset),
      .x_final   (x_final),
      .y_final   (y_final),
      .mul_done  (mul_done),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_idx   (out_idx),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [FIELD_W-1:0] x;
      logic [FIELD_W-1:0] y;
      logic [3:0]         pat;
      logic [15:0][31:0]  exp;
      int                 exp_busy;
      int                 rise_at;
      logic [FIELD_W-1:0] rx;
      logic [FIELD_W-1:0] ry;
      logic               exp_ovr;
   } vec_t;

   vec_t vecs[6];

   logic [15:0][31:0] exp_g;
   logic [15:0][31:0] exp_ones;
   logic [15:0][31:0] exp_12;
   logic [FIELD_W-1:0] ones;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      mul_done  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic collect(input string tag, input logic [15:0][31:0] exp, input logic [3:0] pat,
                          input int rise_at, input logic [FIELD_W-1:0] rx,
                          input logic [FIELD_W-1:0] ry, output int busy_n);
      int   n;
      int   cyc;
      bit   held;
      logic [31:0] hd;
      logic [3:0]  hi;
      logic        hl;
      n = 0; cyc = 0; held = 0; busy_n = 0; hd = '0; hi = '0; hl = 1'b0;
      while (n < 16 && cyc < 200) begin
         if (busy) busy_n++;
         chk($sformatf("%s valid n%0d", tag, n), out_valid, 1);
         if (held) begin
            chk($sformatf("%s hold data n%0d", tag, n), out_data, hd);
            chk($sformatf("%s hold idx n%0d", tag, n), out_idx, hi);
            chk($sformatf("%s hold last n%0d", tag, n), out_last, hl);
         end
         if (rise_at == n) begin
            x_final  = rx;
            y_final  = ry;
            mul_done = 1'b1;
         end
         out_ready = pat[3 - (cyc % 4)];
         if (out_valid && out_ready) begin
            chk($sformatf("%s idx n%0d", tag, n), out_idx, n);
            chk($sformatf("%s data n%0d", tag, n), out_data, exp[15-n]);
            chk($sformatf("%s last n%0d", tag, n), out_last, (n == 15));
            n++;
            held = 0;
         end else begin
            held = 1; hd = out_data; hi = out_idx; hl = out_last;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (n < 16) chk($sformatf("%s words before timeout", tag), n, 16);
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int bn;
      int k;
      int cnt;
      exp_g = 512'h000000FA_C9DFCBAC_8313BB21_39F1BB75_5FEF65BC_391F8B36_F8F8EB73_71FD558B_00000100_6A08A419_03350678_E58528BE_BF8A0BEF_F867A7CA_36716F7E_01F81052;
      exp_ones = {32'h000001FF, {7{32'hFFFFFFFF}}, 32'h000001FF, {7{32'hFFFFFFFF}}};
      exp_12   = {{7{32'h0}}, 32'h1, {7{32'h0}}, 32'h2};
      ones     = '1;

      vecs[0] = '{x:PX, y:PY, pat:4'b1111, exp:exp_g, exp_busy:16, rise_at:-1, rx:'0, ry:'0, exp_ovr:1'b0};
      vecs[1] = '{x:PX, y:PY, pat:4'b1001, exp:exp_g, exp_busy:32, rise_at:-1, rx:'0, ry:'0, exp_ovr:1'b0};
      vecs[2] = '{x:ones, y:ones, pat:4'b1111, exp:exp_ones, exp_busy:16, rise_at:-1, rx:'0, ry:'0, exp_ovr:1'b0};
      vecs[3] = '{x:233'd1, y:233'd2, pat:4'b1010, exp:exp_12, exp_busy:31, rise_at:-1, rx:'0, ry:'0, exp_ovr:1'b0};
      vecs[4] = '{x:PX, y:PY, pat:4'b1111, exp:exp_g, exp_busy:16, rise_at:5, rx:233'd1, ry:233'd2, exp_ovr:1'b1};
      vecs[5] = '{x:PX, y:PY, pat:4'b1111, exp:exp_g, exp_busy:16, rise_at:15, rx:ones, ry:ones, exp_ovr:1'b0};

      reset = 1'b0; mul_done = 1'b0; out_ready = 1'b0; x_final = '0; y_final = '0;
      @(posedge clk); #1;
      chk("reset out_data", out_data, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_last", out_last, 0);
      chk("reset out_idx", out_idx, 0);
      chk("reset busy", busy, 0);
      chk("reset overrun", overrun, 0);
      reset = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle ignores ready", out_valid, 0);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         x_final  = vecs[v].x;
         y_final  = vecs[v].y;
         mul_done = 1'b1;
         @(posedge clk); #1;
         mul_done = 1'b0;
         collect($sformatf("v%0d", v), vecs[v].exp, vecs[v].pat, vecs[v].rise_at,
                 vecs[v].rx, vecs[v].ry, bn);
         chk($sformatf("v%0d busy cycles", v), bn, vecs[v].exp_busy);
         chk($sformatf("v%0d overrun", v), overrun, vecs[v].exp_ovr);
         if (vecs[v].rise_at == 15) begin
            chk("b2b valid", out_valid, 1);
            chk("b2b idx", out_idx, 0);
            chk("b2b data", out_data, 32'h000001FF);
            chk("b2b last", out_last, 0);
            collect("b2b second", exp_ones, 4'b1111, -1, '0, '0, bn);
            chk("b2b second busy", bn, 16);
            chk("b2b second overrun", overrun, 0);
         end
         chk($sformatf("v%0d valid after", v), out_valid, 0);
         chk($sformatf("v%0d busy after", v), busy, 0);
      end

      // Asynchronous abort mid-stream.
      do_reset();
      x_final = PX; y_final = PY; mul_done = 1'b1;
      @(posedge clk); #1;
      mul_done = 1'b0; out_ready = 1'b1;
      k = 0;
      while (out_idx != 4'd9 && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reach idx 9", out_idx, 9);
      #2;
      reset = 1'b0;
      #1;
      chk("abort out_data", out_data, 0);
      chk("abort out_valid", out_valid, 0);
      chk("abort out_idx", out_idx, 0);
      chk("abort out_last", out_last, 0);
      chk("abort busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      cnt = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      chk("no stream after abort", cnt, 0);

      // mul_done already high at reset release, then held for 100 cycles.
      reset = 1'b0; out_ready = 1'b1; x_final = PX; y_final = PY; mul_done = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("level first valid", out_valid, 1);
      chk("level first data", out_data, 32'h000000FA);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (out_valid && out_ready) cnt++;
         @(posedge clk); #1;
      end
      chk("level hold handshakes", cnt, 16);
      chk("level hold overrun", overrun, 0);
      mul_done = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
